// File: rtl/mac_pkg.sv
// Shared MAC constants and the TX pause-gate state encoding.
package mac_pkg;

  localparam int N_SYMBOLS    = 8;
  localparam int W_SYMBOL     = 8;
  localparam int W_QUANTA     = 16;
  localparam int QUANTUM_BITS = 512;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    PAUSED   = 2'd2
  } pause_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-register AXI-Stream forward slice with clock enable; shared by the TX and RX paths.
module axis_reg_slice #(
  parameter int N_SYMBOLS = 8,
  parameter int W_SYMBOL  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          load_i,
  input  logic [N_SYMBOLS*W_SYMBOL-1:0] data_i,
  input  logic [N_SYMBOLS-1:0]          keep_i,
  input  logic                          last_i,
  output logic                          room_o,
  output logic                          m_tvalid_o,
  output logic [N_SYMBOLS-1:0]          m_tkeep_o,
  output logic [N_SYMBOLS*W_SYMBOL-1:0] m_tdata_o,
  output logic                          m_tlast_o,
  input  logic                          m_tready_i
);

  logic                          vld_q;
  logic [N_SYMBOLS-1:0]          keep_q;
  logic [N_SYMBOLS*W_SYMBOL-1:0] data_q;
  logic                          last_q;

  // Room for a new beat if empty or the held beat leaves this cycle.
  assign room_o = ~vld_q | m_tready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      keep_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (en_i) begin
      if (load_i) begin
        vld_q  <= 1'b1;
        keep_q <= keep_i;
        data_q <= data_i;
        last_q <= last_i;
      end else if (m_tready_i) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign m_tvalid_o = vld_q;
  assign m_tkeep_o  = keep_q;
  assign m_tdata_o  = data_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/mac_tx_pause_gate.sv
// 802.3x pause gate on the MAC TX stream: finishes the in-flight frame, then holds
// off new frames for quanta x QUANTUM_BITS bit-times.
module mac_tx_pause_gate #(
  parameter int N_SYMBOLS       = mac_pkg::N_SYMBOLS,
  parameter int W_SYMBOL        = mac_pkg::W_SYMBOL,
  parameter int W_QUANTA        = mac_pkg::W_QUANTA,
  parameter int QUANTUM_BITS    = mac_pkg::QUANTUM_BITS,
  parameter int CYC_PER_QUANTUM = QUANTUM_BITS / (N_SYMBOLS * W_SYMBOL)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clk_en,
  input  logic                          i_pause_en,
  input  logic                          i_pause_valid,
  input  logic [W_QUANTA-1:0]           i_pause_quanta,
  input  logic                          s_axis_tvalid,
  input  logic [N_SYMBOLS-1:0]          s_axis_tkeep,
  input  logic [N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [N_SYMBOLS-1:0]          m_axis_tkeep,
  output logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          o_paused,
  output logic [W_QUANTA-1:0]           o_quanta_left
);

  import mac_pkg::*;

  localparam int CW = $clog2(CYC_PER_QUANTUM) + 1;

  if (CYC_PER_QUANTUM < 1) begin : g_bad_cyc
    $error("CYC_PER_QUANTUM must be >= 1");
  end
  if ((N_SYMBOLS < 1) || (N_SYMBOLS > 64) || ((N_SYMBOLS & (N_SYMBOLS - 1)) != 0)) begin : g_bad_sym
    $error("N_SYMBOLS must be a power of 2 in 1..64");
  end

  pause_state_t        state_q, state_d;
  logic                pending_q, pending_d;
  logic [W_QUANTA-1:0] quanta_q, quanta_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                room, block, accept, wrap, eof;

  assign block  = (state_q == PAUSED) |
                  ((state_q == IDLE) & (pending_q | (quanta_q != '0)));
  assign s_axis_tready = i_clk_en & room & ~block;
  assign accept = s_axis_tvalid & s_axis_tready;
  assign eof    = accept & s_axis_tlast;
  assign wrap   = (cnt_q == CW'(CYC_PER_QUANTUM - 1));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    quanta_d  = quanta_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept && !s_axis_tlast) begin
          state_d = IN_FRAME;
        end else if (quanta_q != '0) begin
          state_d   = PAUSED;
          pending_d = 1'b0;
          cnt_d     = '0;
        end
      end
      IN_FRAME: begin
        if (eof) begin
          state_d   = (pending_q && (quanta_q != '0)) ? PAUSED : IDLE;
          pending_d = 1'b0;
          cnt_d     = '0;
        end
      end
      PAUSED: begin
        if (quanta_q == '0) begin
          state_d = IDLE;
        end else if (wrap) begin
          cnt_d    = '0;
          quanta_d = quanta_q - W_QUANTA'(1);
          if (quanta_q == W_QUANTA'(1)) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A request overrides counting; frames in flight always complete.
    if (!i_pause_en) begin
      pending_d = 1'b0;
      quanta_d  = '0;
      if (state_d == PAUSED) state_d = IDLE;
    end else if (i_pause_valid) begin
      quanta_d = i_pause_quanta;
      cnt_d    = '0;
      if (i_pause_quanta == '0) begin
        pending_d = 1'b0;
        if (state_d == PAUSED) state_d = IDLE;
      end else if (state_q == PAUSED) begin
        state_d = PAUSED;
      end else if (state_q == IN_FRAME) begin
        state_d   = eof ? PAUSED : IN_FRAME;
        pending_d = ~eof;
      end else begin
        state_d   = (accept && !s_axis_tlast) ? IN_FRAME : IDLE;
        pending_d = accept & ~s_axis_tlast;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      quanta_q  <= '0;
      cnt_q     <= '0;
    end else if (i_clk_en) begin
      state_q   <= state_d;
      pending_q <= pending_d;
      quanta_q  <= quanta_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_paused      = (state_q == PAUSED);
  assign o_quanta_left = quanta_q;

  axis_reg_slice #(
    .N_SYMBOLS (N_SYMBOLS),
    .W_SYMBOL  (W_SYMBOL)
  ) u_slice (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .en_i       (i_clk_en),
    .load_i     (accept),
    .data_i     (s_axis_tdata),
    .keep_i     (s_axis_tkeep),
    .last_i     (s_axis_tlast),
    .room_o     (room),
    .m_tvalid_o (m_axis_tvalid),
    .m_tkeep_o  (m_axis_tkeep),
    .m_tdata_o  (m_axis_tdata),
    .m_tlast_o  (m_axis_tlast),
    .m_tready_i (m_axis_tready)
  );

endmodule

// File: tb/tb_mac_tx_pause_gate.sv
// Directed bench for mac_tx_pause_gate at 8 bytes/beat (8 enabled cycles per quantum).
module tb_mac_tx_pause_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        pause_en;
  logic        pause_valid;
  logic [15:0] pause_quanta;
  logic        s_tvalid;
  logic [7:0]  s_tkeep;
  logic [63:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [7:0]  m_tkeep;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic        paused;
  logic [15:0] quanta_left;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_tx_pause_gate dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_clk_en       (clk_en),
    .i_pause_en     (pause_en),
    .i_pause_valid  (pause_valid),
    .i_pause_quanta (pause_quanta),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tdata   (s_tdata),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tdata   (m_tdata),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .o_paused       (paused),
    .o_quanta_left  (quanta_left)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
  endtask

  logic [63:0] pt_data [3] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
  logic [7:0]  pt_keep [3] = '{8'hFF, 8'hFF, 8'h0F};

  initial begin
    int low_cnt, p_cnt, en_edges;
    rst = 1'b1; clk_en = 1'b1; pause_en = 1'b1; pause_valid = 1'b0; pause_quanta = '0;
    s_tvalid = 1'b0; s_tkeep = '0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_paused", paused, 0);
    chk("rst_quanta", quanta_left, 0);
    chk("rst_sready", s_tready, 1);

    // Pass-through of a 3-beat frame, one cycle latency.
    for (int i = 0; i < 3; i++) begin
      beat(pt_data[i], pt_keep[i], i == 2);
      chk("pt_sready", s_tready, 1);
      step();
      chk("pt_mvalid", m_tvalid, 1);
      chk("pt_mdata", m_tdata, pt_data[i]);
      chk("pt_mkeep", m_tkeep, pt_keep[i]);
      chk("pt_mlast", m_tlast, i == 2);
      chk("pt_paused", paused, 0);
    end
    s_tvalid = 1'b0;
    step();
    chk("pt_drain", m_tvalid, 0);

    // Pause while idle: quanta=2 blocks for 2*8 + 1 cycles.
    pause_valid = 1'b1; pause_quanta = 16'd2;
    step();
    pause_valid = 1'b0;
    low_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin chk("idle_q0", quanta_left, 2); chk("idle_p0", paused, 0); end
      if (k == 1) chk("idle_p1", paused, 1);
      if (k == 8) chk("idle_q8", quanta_left, 2);
      if (k == 9) chk("idle_q9", quanta_left, 1);
      if (k == 17) begin
        chk("idle_q17", quanta_left, 0);
        chk("idle_p17", paused, 0);
        chk("idle_rdy17", s_tready, 1);
      end
      if (!s_tready) low_cnt++;
      step();
    end
    chk("idle_low_cycles", low_cnt, 17);

    // Pause requested at beat 2 of 5: frame finishes, then 8 paused cycles.
    for (int i = 0; i < 5; i++) begin
      beat(64'hA0 + i, 8'hFF, i == 4);
      if (i == 1) begin pause_valid = 1'b1; pause_quanta = 16'd1; end
      chk("mid_sready", s_tready, 1);
      step();
      pause_valid = 1'b0;
      chk("mid_mdata", m_tdata, 64'hA0 + i);
      if (i < 4) chk("mid_not_paused", paused, 0);
    end
    beat(64'hBB, 8'h0F, 1'b1);
    p_cnt = 0;
    for (int k = 0; k < 20 && paused; k++) begin
      p_cnt++;
      if (s_tready) chk("mid_blocked", s_tready, 0);
      step();
    end
    chk("mid_paused_cycles", p_cnt, 8);
    chk("mid_resume_rdy", s_tready, 1);
    step();
    s_tvalid = 1'b0;
    chk("mid_next_data", m_tdata, 64'hBB);
    chk("mid_next_keep", m_tkeep, 8'h0F);

    // Refresh to 3 while paused at 98, then XON.
    pause_valid = 1'b1; pause_quanta = 16'd100;
    step();
    pause_valid = 1'b0;
    repeat (20) step();
    chk("ref_q98", quanta_left, 98);
    chk("ref_paused", paused, 1);
    pause_valid = 1'b1; pause_quanta = 16'd3;
    step();
    pause_valid = 1'b0;
    chk("ref_q3", quanta_left, 3);
    repeat (7) step();
    chk("ref_q3_hold", quanta_left, 3);
    step();
    chk("ref_q2", quanta_left, 2);
    pause_valid = 1'b1; pause_quanta = 16'd0;
    step();
    pause_valid = 1'b0;
    chk("xon_paused", paused, 0);
    chk("xon_q", quanta_left, 0);
    chk("xon_rdy", s_tready, 1);

    // Clock-enable gaps during a 1-quantum pause.
    pause_valid = 1'b1; pause_quanta = 16'd1;
    step();
    pause_valid = 1'b0;
    beat(64'hCC, 8'hFF, 1'b1);
    p_cnt = 0; en_edges = 0;
    for (int i = 0; i < 20; i++) begin
      clk_en = i[0];
      if (!clk_en) chk("ce_sready_low", s_tready, 0);
      step();
      if (clk_en && paused) p_cnt++;
      if (clk_en && !paused) break;
      en_edges++;
    end
    clk_en = 1'b1;
    chk("ce_paused_cycles", p_cnt, 8);
    chk("ce_no_accept", m_tvalid, 0);
    s_tvalid = 1'b0;

    // Dropping pause enable releases an active pause.
    pause_valid = 1'b1; pause_quanta = 16'd5;
    step();
    pause_valid = 1'b0;
    step();
    chk("pen_paused", paused, 1);
    pause_en = 1'b0;
    step();
    chk("pen_released", paused, 0);
    chk("pen_q", quanta_left, 0);
    pause_en = 1'b1;

    // Backpressure holds the output beat; reset mid-frame clears it.
    m_tready = 1'b0;
    beat(64'hC1, 8'hFF, 1'b0);
    step();
    beat(64'hC2, 8'hFF, 1'b0);
    chk("bp_valid", m_tvalid, 1);
    chk("bp_data", m_tdata, 64'hC1);
    chk("bp_sready", s_tready, 0);
    step();
    chk("bp_hold_data", m_tdata, 64'hC1);
    chk("bp_hold_valid", m_tvalid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    chk("mrst_tvalid", m_tvalid, 0);
    chk("mrst_tdata", m_tdata, 0);
    chk("mrst_tkeep", m_tkeep, 0);
    chk("mrst_tlast", m_tlast, 0);
    chk("mrst_paused", paused, 0);
    chk("mrst_sready", s_tready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_tx_pause_gate.md
Name: mac_tx_pause_gate

Overview:
- IEEE 802.3x flow-control gate on the MAC TX AXI-Stream path: user source -> mac_tx_pause_gate -> mac_tx_top.
- On a pause request (quanta from the RX pause-frame decoder) it lets any in-flight frame finish, then holds off new frames for quanta x 512 bit-times.
- One registered output slice; frames are never truncated or split.
- Generalises the TX path in datapath width and adds a flow-control mode the base MAC lacks.

Parameters:
- N_SYMBOLS, 8, bytes per beat; must be a power of 2, 1..64.
- W_SYMBOL, 8, bits per symbol.
- W_QUANTA, 16, width of the pause-quanta field.
- QUANTUM_BITS, 512, bit-times per pause quantum.
- CYC_PER_QUANTUM, QUANTUM_BITS/(N_SYMBOLS*W_SYMBOL), derived; enabled cycles per quantum. Must be >=1 (elaboration assert).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clk_en  in  1  clock enable; all state advances only when high.
- i_pause_en  in  1  mode: 1 = honour pause requests; 0 = requests ignored and any active pause cleared.
- i_pause_valid  in  1  one-cycle pause request strobe.
- i_pause_quanta  in  W_QUANTA  requested quanta; 0 = XON (resume).
- s_axis_tvalid  in  1  slave valid.
- s_axis_tkeep  in  N_SYMBOLS  byte enables.
- s_axis_tdata  in  N_SYMBOLS*W_SYMBOL  data.
- s_axis_tlast  in  1  end of frame.
- s_axis_tready  out  1  slave ready.
- m_axis_tvalid  out  1  master valid.
- m_axis_tkeep  out  N_SYMBOLS  byte enables.
- m_axis_tdata  out  N_SYMBOLS*W_SYMBOL  data.
- m_axis_tlast  out  1  end of frame.
- m_axis_tready  in  1  master ready.
- o_paused  out  1  high while in PAUSED.
- o_quanta_left  out  W_QUANTA  remaining quanta.

Behaviour:
- Reset: state IDLE; m_axis_tvalid=0, m_axis_tkeep=0, m_axis_tdata=0, m_axis_tlast=0; o_paused=0; o_quanta_left=0; pending=0; cycle counter=0.
- Output slice: single register stage, latency 1 enabled cycle.
  - Register loads on a slave handshake.
  - m_axis_tvalid clears when m_axis_tready=1 and no new beat is accepted.
  - Data and tkeep are passed through unmodified.
- s_axis_tready = i_clk_en & (!m_axis_tvalid | m_axis_tready) & !block.
  - block = 1 in PAUSED.
  - block = 1 in IDLE when pending=1 or o_quanta_left!=0.
  - block = 0 in IN_FRAME: a frame is never stalled mid-frame by pause.
- i_clk_en=0: all registers hold, s_axis_tready=0, pause strobes ignored.
- FSM:
  - IDLE -> IN_FRAME on an accepted beat with tlast=0. A beat with tlast=1 is a single-beat frame; state stays IDLE.
  - IN_FRAME -> IDLE on an accepted beat with tlast=1 and pending=0 or quanta=0.
  - IN_FRAME -> PAUSED on an accepted beat with tlast=1 and a nonzero latched quanta.
  - IDLE -> PAUSED the cycle after a request with quanta!=0 (or pending with nonzero quanta).
  - PAUSED -> IDLE when o_quanta_left would reach 0 or XON arrives; the transition takes 1 cycle.
- Request handling (i_pause_en=1, i_pause_valid=1):
  - Quanta latch into o_quanta_left, replacing any prior value; never accumulated.
  - Cycle counter resets to 0 on every reload.
  - In IN_FRAME: pending=1 and the value is held until the frame ends.
  - quanta=0: pending cleared, o_quanta_left=0, exit PAUSED next cycle.
- Counting (PAUSED only):
  - Cycle counter runs 0..CYC_PER_QUANTUM-1 on enabled cycles.
  - At wrap, o_quanta_left decrements; leave PAUSED when it goes 1->0.
  - A request in the same cycle as a wrap or decrement wins: it reloads and no decrement occurs.
- i_pause_en falling: pending and o_quanta_left cleared, PAUSED -> IDLE next enabled cycle. An in-flight frame is unaffected.
- Reset mid-frame: output beat dropped (tvalid=0). Downstream mac_tx_top is reset alongside it.
- Arithmetic: the cycle counter is $clog2(CYC_PER_QUANTUM)+1 bits; o_quanta_left saturates at 0 and never underflows.

Decomposition:
- mac_pkg: N_SYMBOLS, W_SYMBOL, W_QUANTA, QUANTUM_BITS, and a pause_state_t enum {IDLE, IN_FRAME, PAUSED}.
- Sub-module axis_reg_slice: the registered output stage, parametrised on N_SYMBOLS and W_SYMBOL, reusable on the RX path.
- Pause FSM and counters stay in mac_tx_pause_gate.

Test Plan:
- Pass-through, no pause: 3-beat frame, tdata 0x11.., 0x22.., 0x33.., tkeep 0xFF,0xFF,0x0F, m_axis_tready=1 -> identical beats on master, 1 cycle later; o_paused=0 throughout.
- Pause while idle: quanta=2, CYC_PER_QUANTUM=8 -> s_axis_tready=0 for 17 cycles; o_quanta_left steps 2->1->0; tready returns the following cycle.
- Pause mid-frame: request quanta=1 at beat 2 of 5 -> all 5 beats pass, then o_paused=1 for 8 enabled cycles, then the next frame is accepted.
- XON and refresh: quanta=100 then, 20 cycles later, quanta=3 -> counter reloads to 3; later quanta=0 -> o_paused drops next cycle.
- Clock enable gaps: i_clk_en toggling 1,0,1,0 during a pause of quanta=1 -> release after exactly 8 enabled cycles; no beats accepted while enable is low.
- Backpressure and reset: m_axis_tready=0 holds an output beat stable; i_reset mid-frame -> all outputs are at reset values the next cycle.
